piso_serializer: RTL

//  Parallel-in serial-out stage feeding the SIPO shift register's sin input.

---
 rtl/piso_serializer_pkg.sv | 16 +
 rtl/piso_serializer_if.sv | 42 ++++
 rtl/piso_serializer_bit_counter.sv | 39 +++
 rtl/piso_serializer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
//   state_e : FSM encoding (ST_IDLE, ST_SHIFT, ST_PARITY)
//   cnt_w() : bit-counter width for a given frame width, $clog2(width+1)
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle of the serializer.
//   din        : parallel word to serialize (producer -> serializer)
//   din_valid  : din is presented
//   din_ready  : serializer accepts din on this edge
//   sout       : serial bit
//   sout_valid : sout carries a frame bit this cycle
//   busy       : frame in progress
//   frame_done : cycle carrying the final bit of a frame
// master = producer/consumer side, slave = serializer side.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Frame bit counter: counts 0..WIDTH-1 and saturates on the last value.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (count -> 0)
//   i_load : restart the count at 0 (takes priority over i_en)
//   i_en   : advance the count
//   o_cnt  : current bit index
//   o_tc   : terminal count, high while o_cnt == WIDTH-1
module piso_serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer. Accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per clock on sout, with gapless back-to-back frames.
// Optional feature macro: PIPO_PARITY_EN appends an even-parity bit to every frame.
//   i_clk : clock, all state updates on posedge
//   i_rst : synchronous active-high reset; aborts any frame in progress
//   bus   : piso_serializer_if.slave (din/din_valid/din_ready, sout/sout_valid,
//           busy, frame_done)
// Parameters: WIDTH (>=2) data bits per frame; MSB_FIRST selects din[WIDTH-1] or din[0]
// as the first bit on the line.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  piso_serializer_if.slave     bus
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
`ifdef PIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  state_e           r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_frame_done;
`ifdef PIPO_PARITY_EN
  logic             r_par;
`endif

  logic             w_ready;
  logic             w_accept;
  logic             w_final;
  logic             w_tc;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_nxt;

  // Final-bit cycle: the only SHIFT/PARITY cycle in which a new word may be taken.
`ifdef PIPO_PARITY_EN
  assign w_final = (r_state == ST_PARITY);
`else
  assign w_final = (r_state == ST_SHIFT) && w_tc;
`endif

  assign w_ready  = !i_rst && ((r_state == ST_IDLE) || w_final);
  assign w_accept = bus.din_valid && w_ready;
  assign w_cnt_en = (r_state == ST_SHIFT) && !w_accept;

  // The bit on the line always sits at the outgoing end of r_shift, so the next
  // bit is its neighbour and the register moves one place per cycle.
  assign w_first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
  assign w_shift_nxt = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  piso_serializer_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_accept),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef PIPO_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_accept) begin
      // New frame: first bit goes out on the very edge that captures the word.
      r_state      <= ST_SHIFT;
      r_shift      <= bus.din;
      r_sout       <= w_first_bit;
      r_sout_valid <= 1'b1;
      r_frame_done <= 1'b0;
`ifdef PIPO_PARITY_EN
      r_par        <= ^bus.din;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_frame_done <= 1'b0;
        end
        ST_SHIFT: begin
          if (w_tc) begin
`ifdef PIPO_PARITY_EN
            r_state      <= ST_PARITY;
            r_sout       <= r_par;
            r_sout_valid <= 1'b1;
            r_frame_done <= 1'b1;
`else
            r_state      <= ST_IDLE;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_frame_done <= 1'b0;
`endif
          end else begin
            r_shift      <= w_shift_nxt;
            r_sout       <= w_next_bit;
            r_sout_valid <= 1'b1;
            // Moving onto the last data bit; that ends the frame unless parity follows.
            r_frame_done <= !PARITY_EN && (w_cnt == PRE_LAST);
          end
        end
`ifdef PIPO_PARITY_EN
        ST_PARITY: begin
          r_state      <= ST_IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_frame_done <= 1'b0;
        end
`endif
        default: begin
          r_state      <= ST_IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready  = w_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_done = r_frame_done;

endmodule
